sort_ctrl: RTL and testbench
============================

SORT_CTRL -- requirements
Module: sort_ctrl

Interface
REQ-001 Parameter DATA_WIDTH, default 8, SHALL set the element width and the SRAM data width.
REQ-002 Parameter ADDR_WIDTH, default 4, SHALL set the SRAM address width; N = 2**ADDR_WIDTH elements.
REQ-003 Port clk, input, 1 bit, SHALL be the single clock; every register updates on its rising edge.
REQ-004 Port reset, input, 1 bit, SHALL be a synchronous, active-high reset.
REQ-005 Port start, input, 1 bit, SHALL request one in-place sort of SRAM words 0..N-1.
REQ-006 Port busy, output, 1 bit, SHALL be high from the cycle after start is accepted through the last SRAM access.
REQ-007 Port done, output, 1 bit, SHALL pulse high for exactly one cycle when the sort completes.
REQ-008 Port swap_cnt, output, 2*ADDR_WIDTH bits, SHALL give the number of swaps performed in the current or last sort.
REQ-009 Port sram_en, output, 1 bit, SHALL drive the SRAM enable.
REQ-010 Port sram_we, output, 1 bit, SHALL drive the SRAM write enable.
REQ-011 Port sram_addr, output, ADDR_WIDTH bits, SHALL drive the SRAM address.
REQ-012 Port sram_wdata, output, DATA_WIDTH bits, SHALL drive the SRAM write data.
REQ-013 Port sram_rdata, input, DATA_WIDTH bits, SHALL take SRAM read data, valid one cycle after a read address is presented (registered read).

Function
REQ-014 The block SHALL sort in place into descending unsigned order using bubble sort: pass p = 0..N-2, index j = 0..N-2-p, comparing word j with word j+1.
REQ-015 FSM states SHALL be IDLE, RD_A, RD_B, CMP, WR_A, WR_B and DONE.
REQ-016 IDLE: sram_en=0, sram_we=0; start=1 SHALL clear j, p, swap_cnt and swapped_flag, and move the FSM to RD_A.
REQ-017 RD_A SHALL drive en=1, we=0, addr=j, then go to RD_B.
REQ-018 RD_B SHALL drive en=1, we=0, addr=j+1, latch sram_rdata into A, then go to CMP.
REQ-019 CMP SHALL drive en=0, latch sram_rdata into B, then:
  - if A < B: go to WR_A;
  - otherwise: advance the index (REQ-022).
REQ-020 Ties (A == B) SHALL NOT swap.
REQ-021 WR_A SHALL write B to address j (en=1, we=1). WR_B SHALL write A to address j+1, increment swap_cnt, set swapped_flag, then advance the index.
REQ-022 Index advance SHALL run in the same cycle, with no extra state:
  - if j < N-2-p: j+1, go to RD_A;
  - else if swapped_flag=0 or p = N-2: go to DONE;
  - else: p+1, j=0, clear swapped_flag, go to RD_A.
REQ-023 DONE SHALL assert done=1 for one cycle with busy=0 and en=0, then return to IDLE.
REQ-024 Cycle cost SHALL be 3 cycles per compare without a swap and 5 cycles per compare with a swap.
REQ-025 start SHALL be ignored in every state except IDLE.
REQ-026 swap_cnt SHALL hold its value after DONE until the next accepted start.
REQ-027 sram_we SHALL never be high while sram_en is low.
REQ-028 sram_addr and sram_wdata SHALL be 0 whenever sram_en=0.

Reset
REQ-029 On reset=1 at a clock edge the FSM SHALL go to IDLE and all outputs SHALL be 0: busy, done, swap_cnt, sram_en, sram_we, sram_addr, sram_wdata.
REQ-030 Reset mid-sort SHALL abort with no further SRAM access; memory may be left partially sorted, and any write already issued in that cycle completes.
REQ-031 Reset SHALL take priority over start in the same cycle.

Structure
REQ-032 Package sort_pkg SHALL hold the FSM state enum and the default DATA_WIDTH and ADDR_WIDTH constants.
REQ-033 The block SHALL be a single module with no sub-module; the comparator is inline logic.

Verification
REQ-034 Scenario 1: SRAM holds 34,215,122,17,77,67,63,194,139,24,71,244,246,40,247,66; pulse start -> done pulses once; memory reads 247,246,244,215,194,139,122,77,71,67,66,63,40,34,24,17.
REQ-035 Scenario 2: memory already descending 15..0; pulse start -> swap_cnt=0; done high in cycle 46 after the start edge (one pass of 15 compares x 3 cycles).
REQ-036 Scenario 3: memory ascending 0..15 -> swap_cnt=120; memory is 15..0; every write satisfies we=1 and en=1.
REQ-037 Scenario 4: all words = 8'd9 -> no write cycles; swap_cnt=0; done after one pass.
REQ-038 Scenario 5: reset asserted in cycle 20 of a sort -> next cycle busy=0, sram_en=0, swap_cnt=0; no SRAM access until a new start; a restart then sorts correctly.
REQ-039 Scenario 6: start held high for the whole sort -> exactly one sort runs; a second sort begins only when start is seen in IDLE after DONE.

Source files
------------

// File: rtl/sort_pkg.sv
// sort_pkg: shared FSM state encoding and default geometry for sort_ctrl.
package sort_pkg;
    localparam int DEF_DATA_WIDTH = 8;
    localparam int DEF_ADDR_WIDTH = 4;
    typedef enum logic [2:0] {IDLE, RD_A, RD_B, CMP, WR_A, WR_B, DONE} state_t;
endpackage

// File: rtl/sort_ctrl.sv
// sort_ctrl: in-place descending bubble sort of an external SRAM with registered read.
module sort_ctrl
    import sort_pkg::*;
#(
    parameter int DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int ADDR_WIDTH = DEF_ADDR_WIDTH
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    start,
    output logic                    busy,
    output logic                    done,
    output logic [2*ADDR_WIDTH-1:0] swap_cnt,
    output logic                    sram_en,
    output logic                    sram_we,
    output logic [ADDR_WIDTH-1:0]   sram_addr,
    output logic [DATA_WIDTH-1:0]   sram_wdata,
    input  logic [DATA_WIDTH-1:0]   sram_rdata
);
    localparam logic [ADDR_WIDTH-1:0] LAST_IDX = ADDR_WIDTH'(2**ADDR_WIDTH - 2);
    state_t state;
    logic [ADDR_WIDTH-1:0] j, p;
    logic [DATA_WIDTH-1:0] a;
    logic swapped, adv, sw_eff, row_end, all_done;
    always_comb begin
        adv = (state == CMP && !(a < sram_rdata)) || state == WR_B;
        sw_eff = swapped || state == WR_B;
        row_end = j == LAST_IDX - p;
        all_done = !sw_eff || p == LAST_IDX;
    end
    // Outputs are registered for the state being entered, so they line up with that state's cycle.
    always_ff @(posedge clk) begin
        sram_en <= 1'b0;
        sram_we <= 1'b0;
        sram_addr <= '0;
        sram_wdata <= '0;
        done <= 1'b0;
        if (reset) begin
            state <= IDLE;
            busy <= 1'b0;
            swap_cnt <= '0;
            j <= '0;
            p <= '0;
            swapped <= 1'b0;
            a <= '0;
        end else begin
            case (state)
                IDLE: if (start) begin
                    j <= '0;
                    p <= '0;
                    swap_cnt <= '0;
                    swapped <= 1'b0;
                    busy <= 1'b1;
                    state <= RD_A;
                    sram_en <= 1'b1;
                end
                RD_A: begin
                    state <= RD_B;
                    sram_en <= 1'b1;
                    sram_addr <= j + 1'b1;
                end
                RD_B: begin
                    state <= CMP;
                    a <= sram_rdata;
                end
                // B is captured straight into the write-data register for WR_A.
                CMP: if (a < sram_rdata) begin
                    state <= WR_A;
                    sram_en <= 1'b1;
                    sram_we <= 1'b1;
                    sram_addr <= j;
                    sram_wdata <= sram_rdata;
                end
                WR_A: begin
                    state <= WR_B;
                    sram_en <= 1'b1;
                    sram_we <= 1'b1;
                    sram_addr <= j + 1'b1;
                    sram_wdata <= a;
                end
                WR_B: begin
                    swap_cnt <= swap_cnt + 1'b1;
                    swapped <= 1'b1;
                end
                default: state <= IDLE;
            endcase
            if (adv) begin
                if (!row_end) begin
                    j <= j + 1'b1;
                    state <= RD_A;
                    sram_en <= 1'b1;
                    sram_addr <= j + 1'b1;
                end else if (all_done) begin
                    state <= DONE;
                    busy <= 1'b0;
                    done <= 1'b1;
                end else begin
                    p <= p + 1'b1;
                    j <= '0;
                    swapped <= 1'b0;
                    state <= RD_A;
                    sram_en <= 1'b1;
                end
            end
        end
    end
endmodule

// File: tb/tb_sort_ctrl.sv
// tb_sort_ctrl: directed scenarios against an SRAM model with a sorted-result scoreboard.
module tb_sort_ctrl;
    logic clk, reset, start, busy, done, sram_en, sram_we;
    logic [7:0] swap_cnt, sram_wdata, sram_rdata;
    logic [3:0] sram_addr;
    logic [7:0] mem [16];
    logic [7:0] exp_q [$];
    int checks = 0, failures = 0, viol = 0, writes = 0, accesses = 0, exp_swaps = 0, cyc = 0;
    logic hold = 1'b0;
    localparam logic [7:0] S1 [16] = '{34, 215, 122, 17, 77, 67, 63, 194, 139, 24, 71, 244, 246, 40, 247, 66};

    sort_ctrl dut (
        .clk(clk), .reset(reset), .start(start), .busy(busy), .done(done), .swap_cnt(swap_cnt),
        .sram_en(sram_en), .sram_we(sram_we), .sram_addr(sram_addr), .sram_wdata(sram_wdata),
        .sram_rdata(sram_rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (sram_en) begin
            accesses++;
            if (sram_we) begin
                mem[sram_addr] = sram_wdata;
                writes++;
            end else sram_rdata <= mem[sram_addr];
        end
    end

    always @(negedge clk)
        if ((sram_we && !sram_en) || (!sram_en && (sram_addr != 0 || sram_wdata != 0))) viol++;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic push_expected();
        logic [7:0] t [16];
        logic [7:0] x;
        t = mem;
        exp_swaps = 0;
        for (int i = 0; i < 16; i++)
            for (int k = i + 1; k < 16; k++)
                if (t[i] < t[k]) exp_swaps++;
        for (int i = 0; i < 16; i++)
            for (int k = i + 1; k < 16; k++)
                if (t[k] > t[i]) begin
                    x = t[i];
                    t[i] = t[k];
                    t[k] = x;
                end
        for (int i = 0; i < 16; i++) exp_q.push_back(t[i]);
    endtask

    task automatic run(input string tag, output int n);
        writes = 0;
        n = 0;
        @(negedge clk);
        start = 1'b1;
        do begin
            @(negedge clk);
            start = hold;
            n++;
        end while (!done && n < 1000);
        chk({tag, "_done_seen"}, done, 1);
        chk({tag, "_busy_in_done"}, busy, 0);
        for (int i = 0; i < 16; i++) chk($sformatf("%s_mem%0d", tag, i), mem[i], exp_q.pop_front());
        chk({tag, "_swap_cnt"}, swap_cnt, exp_swaps);
        chk({tag, "_invariants"}, viol, 0);
        @(negedge clk);
        chk({tag, "_done_pulse"}, done, 0);
    endtask

    initial begin
        reset = 1'b1;
        start = 1'b1;
        repeat (3) @(negedge clk);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_swap", swap_cnt, 0);
        chk("rst_en", sram_en, 0);
        chk("rst_we", sram_we, 0);
        chk("rst_addr", sram_addr, 0);
        chk("rst_wdata", sram_wdata, 0);
        reset = 1'b0;
        start = 1'b0;

        for (int i = 0; i < 16; i++) mem[i] = S1[i];
        push_expected();
        run("s1", cyc);
        chk("s1_top", mem[0], 247);
        chk("s1_bottom", mem[15], 17);

        for (int i = 0; i < 16; i++) mem[i] = 8'(15 - i);
        push_expected();
        run("s2", cyc);
        chk("s2_done_cycle", cyc, 46);
        chk("s2_writes", writes, 0);

        for (int i = 0; i < 16; i++) mem[i] = 8'(i);
        push_expected();
        run("s3", cyc);
        chk("s3_swaps120", swap_cnt, 120);
        chk("s3_writes", writes, 240);

        for (int i = 0; i < 16; i++) mem[i] = 8'd9;
        push_expected();
        run("s4", cyc);
        chk("s4_writes", writes, 0);
        chk("s4_done_cycle", cyc, 46);
        chk("s4_swap_hold", swap_cnt, 0);

        for (int i = 0; i < 16; i++) mem[i] = 8'(i);
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (19) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        chk("s5_busy", busy, 0);
        chk("s5_en", sram_en, 0);
        chk("s5_swap", swap_cnt, 0);
        reset = 1'b0;
        accesses = 0;
        repeat (10) @(negedge clk);
        chk("s5_no_access", accesses, 0);
        push_expected();
        run("s5b", cyc);

        for (int i = 0; i < 16; i++) mem[i] = S1[i];
        push_expected();
        hold = 1'b1;
        run("s6", cyc);
        chk("s6_idle_gap", busy, 0);
        @(negedge clk);
        chk("s6_restart", busy, 1);
        hold = 1'b0;
        start = 1'b0;
        cyc = 0;
        do begin
            @(negedge clk);
            cyc++;
        end while (!done && cyc < 1000);
        chk("s6b_done_seen", done, 1);
        chk("s6b_swap_cnt", swap_cnt, 0);
        chk("s6b_top", mem[0], 247);
        chk("s6b_invariants", viol, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
